// File: rtl/chirp_seq_pkg.sv
// Shared types and sizing helpers for the chirp sequencer slice.
package chirp_seq_pkg;

    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_NPROF     = 4;
    localparam int DEF_FRAME_LEN = 10;
    localparam int DEF_CW        = 8;

    // Width of a profile index; a single-slot table still needs one bit.
    function automatic int idx_width(input int nprof);
        return (nprof < 2) ? 1 : $clog2(nprof);
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NPROF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2,
        GAP  = 2'd3
    } seq_state_e;

    // Profile record at the default widths, for hosts that build table images.
    typedef struct packed {
        logic [DEF_DWIDTH-1:0] step;
        logic [DEF_CW-1:0]     nramp;
        logic [DEF_CW-1:0]     gap;
    } profile_t;

endpackage

// File: rtl/chirp_sequencer_if.sv
// Host configuration bus for the chirp sequencer: table writes and sequence setup.
interface chirp_sequencer_if
    import chirp_seq_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int NPROF  = DEF_NPROF,
    parameter int CW     = DEF_CW
) ();
    localparam int IDX_W = idx_width(NPROF);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [DWIDTH-1:0] cfg_step;
    logic [CW-1:0]     cfg_nramp;
    logic [CW-1:0]     cfg_gap;
    logic [IDX_W:0]    nprof_act;
    logic              loop;

    modport master (
        output cfg_we, cfg_addr, cfg_step, cfg_nramp, cfg_gap, nprof_act, loop
    );

    modport slave (
        input cfg_we, cfg_addr, cfg_step, cfg_nramp, cfg_gap, nprof_act, loop
    );
endinterface

// File: rtl/chirp_sequencer_frame_timer.sv
// Modulo-FRAME_LEN frame counter that runs while enabled and emits the dce_n strobe.
module dac_frame_timer #(
    parameter int FRAME_LEN = 10
) (
    input  logic clk10m,
    input  logic rst_n,
    input  logic en,
    input  logic en_next,
    output logic dce_n,
    output logic frame_tick
);
    localparam int TW = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN);
    localparam logic [TW-1:0] LAST = TW'(FRAME_LEN - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          dce_n_q, dce_n_d;

    // Strobe is gated by the next-cycle enable so an abort never leaves a stray strobe in IDLE.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        dce_n_d = !(en_next && (cnt_d == LAST));
    end

    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dce_n_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            dce_n_q <= dce_n_d;
        end
    end

    assign dce_n      = dce_n_q;
    assign frame_tick = !dce_n_q;
endmodule

// File: rtl/chirp_sequencer.sv
// Steps through a table of chirp profiles, presenting each step size to the DAC
// interface for a number of ramps followed by an idle gap measured in frames.
module chirp_sequencer
    import chirp_seq_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int NPROF     = DEF_NPROF,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CW        = DEF_CW,
    localparam int IDX_W    = idx_width(NPROF)
) (
    input  logic               clk10m,
    input  logic               rst_n,
    chirp_sequencer_if.slave   cfg,
    input  logic               start,
    input  logic               stop,
    input  logic               wrap,
    output logic [DWIDTH-1:0]  stepsize,
    output logic               dce_n,
    output logic               chirp_n,
    output logic [IDX_W-1:0]   prof_idx,
    output logic               busy,
    output logic               done
);
    localparam int AW = IDX_W + 1;

    typedef struct packed {
        logic [DWIDTH-1:0] step;
        logic [CW-1:0]     nramp;
        logic [CW-1:0]     gap;
    } prof_t;

    prof_t             tbl_q [NPROF];
    prof_t             tbl_d [NPROF];
    prof_t             wk_q, wk_d;
    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     ramp_cnt_q, ramp_cnt_d;
    logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [DWIDTH-1:0] stepsize_q, stepsize_d;
    logic              chirp_n_q, chirp_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [AW-1:0]     nact_eff;
    logic              more;
    logic              go_next;
    logic              frame_tick;

    always_comb begin
        for (int i = 0; i < NPROF; i++) begin
            tbl_d[i] = tbl_q[i];
        end
        if (cfg.cfg_we) begin
            tbl_d[cfg.cfg_addr] = '{step: cfg.cfg_step, nramp: cfg.cfg_nramp, gap: cfg.cfg_gap};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPROF; gi++) begin : g_slot
            always_ff @(posedge clk10m or negedge rst_n) begin
                if (!rst_n) begin
                    tbl_q[gi] <= '0;
                end else begin
                    tbl_q[gi] <= tbl_d[gi];
                end
            end
        end
    endgenerate

    // An active count of 0 means one profile; anything above the table size is clamped.
    always_comb begin
        if (cfg.nprof_act == '0) begin
            nact_eff = AW'(1);
        end else if (cfg.nprof_act > AW'(NPROF)) begin
            nact_eff = AW'(NPROF);
        end else begin
            nact_eff = cfg.nprof_act;
        end
        more = ({1'b0, idx_q} + AW'(1)) < nact_eff;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wk_d       = wk_q;
        ramp_cnt_d = ramp_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        go_next    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                wk_d       = tbl_q[idx_q];
                ramp_cnt_d = '0;
                gap_cnt_d  = '0;
                if (tbl_q[idx_q].nramp != '0) begin
                    state_d = RAMP;
                end else if (tbl_q[idx_q].gap != '0) begin
                    state_d = GAP;
                end else begin
                    go_next = 1'b1;
                end
            end
            RAMP: begin
                if (wrap) begin
                    ramp_cnt_d = ramp_cnt_q + 1'b1;
                    if (ramp_cnt_d == wk_q.nramp) begin
                        if (wk_q.gap != '0) begin
                            state_d = GAP;
                        end else begin
                            go_next = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (frame_tick) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == wk_q.gap) begin
                        go_next = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_next) begin
            if (more) begin
                idx_d   = idx_q + 1'b1;
                state_d = LOAD;
            end else if (cfg.loop) begin
                idx_d   = '0;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d     = (state_d != IDLE);
        chirp_n_d  = (state_d != RAMP);
        stepsize_d = (state_d == RAMP) ? wk_d.step : '0;
    end

    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wk_q       <= '0;
            ramp_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stepsize_q <= '0;
            chirp_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wk_q       <= wk_d;
            ramp_cnt_q <= ramp_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            stepsize_q <= stepsize_d;
            chirp_n_q  <= chirp_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    dac_frame_timer #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_timer (
        .clk10m     (clk10m),
        .rst_n      (rst_n),
        .en         (busy_q),
        .en_next    (busy_d),
        .dce_n      (dce_n),
        .frame_tick (frame_tick)
    );

    assign stepsize = stepsize_q;
    assign chirp_n  = chirp_n_q;
    assign prof_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench: each step schedules expected output values per cycle into a
// scoreboard queue, and a negedge monitor pops and checks them as cycles elapse.
module tb_chirp_sequencer;

    logic       clk10m = 1'b0;
    logic       rst_n;
    logic       start, stop, wrap;
    logic [7:0] stepsize;
    logic       dce_n, chirp_n, busy, done;
    logic [1:0] prof_idx;

    chirp_sequencer_if #(.DWIDTH(8), .NPROF(4), .CW(8)) cfg_bus ();

    chirp_sequencer #(
        .DWIDTH    (8),
        .NPROF     (4),
        .FRAME_LEN (10),
        .CW        (8)
    ) dut (
        .clk10m   (clk10m),
        .rst_n    (rst_n),
        .cfg      (cfg_bus),
        .start    (start),
        .stop     (stop),
        .wrap     (wrap),
        .stepsize (stepsize),
        .dce_n    (dce_n),
        .chirp_n  (chirp_n),
        .prof_idx (prof_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk10m = ~clk10m;

    int cyc = 0;
    always @(posedge clk10m) cyc <= cyc + 1;

    typedef enum int {S_STEP, S_CHIRP, S_DCE, S_BUSY, S_DONE, S_IDX} sig_e;
    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_STEP:  return 32'(stepsize);
            S_CHIRP: return 32'(chirp_n);
            S_DCE:   return 32'(dce_n);
            S_BUSY:  return 32'(busy);
            S_DONE:  return 32'(done);
            default: return 32'(prof_idx);
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sig_e s, input int from, input int to, input int val);
        for (int c = from; c <= to; c++) begin
            sb.push_back('{cyc: c, sig: s, val: val, tag: tag});
        end
    endtask

    task automatic expect_reset_vals(input string tag, input int from, input int to);
        expect_sig(tag, S_STEP, from, to, 0);
        expect_sig(tag, S_DCE, from, to, 1);
        expect_sig(tag, S_CHIRP, from, to, 1);
        expect_sig(tag, S_IDX, from, to, 0);
        expect_sig(tag, S_BUSY, from, to, 0);
        expect_sig(tag, S_DONE, from, to, 0);
    endtask

    always @(negedge clk10m) begin
        logic [31:0] obs;
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                obs = observe(sb[i].sig);
                checks++;
                assert (obs === 32'(sb[i].val)) else begin
                    errors++;
                    $error("FAIL %s %s cyc=%0d: observed %0d expected %0d",
                           sb[i].tag, sb[i].sig.name(), cyc, obs, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk10m);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] s, input logic [7:0] n, input logic [7:0] g);
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_step  = s;
        cfg_bus.cfg_nramp = n;
        cfg_bus.cfg_gap   = g;
        cfg_bus.cfg_we    = 1'b1;
        tick();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int t0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        wrap  = 1'b0;
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_step  = '0;
        cfg_bus.cfg_nramp = '0;
        cfg_bus.cfg_gap   = '0;
        cfg_bus.nprof_act = 3'd1;
        cfg_bus.loop      = 1'b0;

        expect_reset_vals("reset_state", 1, 3);
        wait_cyc(3);
        rst_n = 1'b1;
        tick();

        // Basic: one profile {5,2,3}, two wraps, stray wrap during GAP.
        cfg_write(2'd0, 8'd5, 8'd2, 8'd3);
        tick();
        t0 = cyc;
        expect_sig("basic_idle", S_BUSY, t0, t0, 0);
        expect_sig("basic_load", S_BUSY, t0 + 1, t0 + 30, 1);
        expect_sig("basic_load", S_CHIRP, t0 + 1, t0 + 1, 1);
        expect_sig("basic_ramp", S_CHIRP, t0 + 2, t0 + 6, 0);
        expect_sig("basic_ramp", S_STEP, t0 + 2, t0 + 6, 5);
        expect_sig("basic_gap", S_CHIRP, t0 + 7, t0 + 40, 1);
        expect_sig("basic_gap", S_STEP, t0 + 7, t0 + 40, 0);
        expect_sig("basic_dce", S_DCE, t0, t0 + 9, 1);
        expect_sig("basic_dce", S_DCE, t0 + 10, t0 + 10, 0);
        expect_sig("basic_dce", S_DCE, t0 + 11, t0 + 19, 1);
        expect_sig("basic_dce", S_DCE, t0 + 20, t0 + 20, 0);
        expect_sig("basic_dce", S_DCE, t0 + 21, t0 + 29, 1);
        expect_sig("basic_dce", S_DCE, t0 + 30, t0 + 30, 0);
        expect_sig("basic_dce_idle", S_DCE, t0 + 31, t0 + 45, 1);
        expect_sig("basic_done", S_DONE, t0, t0 + 30, 0);
        expect_sig("basic_done", S_DONE, t0 + 31, t0 + 31, 1);
        expect_sig("basic_done", S_DONE, t0 + 32, t0 + 33, 0);
        expect_sig("basic_end", S_BUSY, t0 + 31, t0 + 33, 0);
        pulse_start();
        wait_cyc(t0 + 4);  wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 6);  wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 15); wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 46);

        // Three looping profiles, then stop mid-RAMP.
        cfg_write(2'd0, 8'd1, 8'd1, 8'd1);
        cfg_write(2'd1, 8'd2, 8'd1, 8'd1);
        cfg_write(2'd2, 8'd3, 8'd1, 8'd1);
        cfg_bus.nprof_act = 3'd3;
        cfg_bus.loop      = 1'b1;
        tick();
        t0 = cyc;
        expect_sig("loop_idx0", S_IDX, t0 + 1, t0 + 10, 0);
        expect_sig("loop_step1", S_STEP, t0 + 2, t0 + 3, 1);
        expect_sig("loop_gap0", S_STEP, t0 + 4, t0 + 4, 0);
        expect_sig("loop_idx1", S_IDX, t0 + 11, t0 + 13, 1);
        expect_sig("loop_step2", S_STEP, t0 + 12, t0 + 13, 2);
        expect_sig("loop_gap1", S_STEP, t0 + 14, t0 + 14, 0);
        expect_sig("loop_idx2", S_IDX, t0 + 21, t0 + 23, 2);
        expect_sig("loop_step3", S_STEP, t0 + 22, t0 + 23, 3);
        expect_sig("loop_wrap_idx0", S_IDX, t0 + 31, t0 + 34, 0);
        expect_sig("loop_wrap_step1", S_STEP, t0 + 32, t0 + 34, 1);
        expect_sig("loop_wrap_chirp", S_CHIRP, t0 + 32, t0 + 34, 0);
        expect_sig("loop_no_done", S_DONE, t0, t0 + 40, 0);
        expect_sig("loop_busy", S_BUSY, t0 + 1, t0 + 34, 1);
        expect_sig("abort_busy", S_BUSY, t0 + 35, t0 + 40, 0);
        expect_sig("abort_step", S_STEP, t0 + 35, t0 + 40, 0);
        expect_sig("abort_chirp", S_CHIRP, t0 + 35, t0 + 40, 1);
        expect_sig("abort_dce", S_DCE, t0 + 35, t0 + 45, 1);
        pulse_start();
        wait_cyc(t0 + 3);  wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 13); wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 23); wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 34); stop = 1'b1; tick(); stop = 1'b0;
        wait_cyc(t0 + 46);

        // Zero-field skips plus a live rewrite of slot 1 while slot 0 runs.
        cfg_write(2'd0, 8'd7, 8'd0, 8'd4);
        cfg_write(2'd1, 8'd9, 8'd3, 8'd5);
        cfg_write(2'd2, 8'd8, 8'd0, 8'd0);
        cfg_bus.nprof_act = 3'd3;
        cfg_bus.loop      = 1'b0;
        tick();
        t0 = cyc;
        expect_sig("skip_no_chirp", S_CHIRP, t0, t0 + 41, 1);
        expect_sig("skip_no_step", S_STEP, t0, t0 + 41, 0);
        expect_sig("skip_busy", S_BUSY, t0 + 1, t0 + 44, 1);
        expect_sig("skip_idx0", S_IDX, t0 + 1, t0 + 40, 0);
        expect_sig("live_idx1", S_IDX, t0 + 41, t0 + 43, 1);
        expect_sig("live_step", S_STEP, t0 + 42, t0 + 43, 6);
        expect_sig("live_chirp", S_CHIRP, t0 + 42, t0 + 43, 0);
        expect_sig("zero_idx2", S_IDX, t0 + 44, t0 + 44, 2);
        expect_sig("zero_step", S_STEP, t0 + 44, t0 + 46, 0);
        expect_sig("zero_chirp", S_CHIRP, t0 + 44, t0 + 46, 1);
        expect_sig("zero_done", S_DONE, t0 + 44, t0 + 44, 0);
        expect_sig("zero_done", S_DONE, t0 + 45, t0 + 45, 1);
        expect_sig("zero_busy", S_BUSY, t0 + 45, t0 + 46, 0);
        pulse_start();
        wait_cyc(t0 + 5);
        cfg_write(2'd1, 8'd6, 8'd1, 8'd0);
        wait_cyc(t0 + 43); wrap = 1'b1; tick(); wrap = 1'b0;
        wait_cyc(t0 + 48);

        // Start and stop together in IDLE.
        t0 = cyc;
        expect_sig("startstop_busy", S_BUSY, t0 + 1, t0 + 4, 0);
        expect_sig("startstop_chirp", S_CHIRP, t0 + 1, t0 + 4, 1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        wait_cyc(t0 + 5);

        // Reset during GAP of slot 1, then the cleared table must behave as all zeros.
        cfg_write(2'd0, 8'd4, 8'd0, 8'd1);
        cfg_write(2'd1, 8'd5, 8'd0, 8'd50);
        cfg_bus.nprof_act = 3'd2;
        tick();
        t0 = cyc;
        expect_sig("prerst_idx", S_IDX, t0 + 14, t0 + 14, 1);
        expect_sig("prerst_busy", S_BUSY, t0 + 14, t0 + 14, 1);
        expect_reset_vals("rst_mid", t0 + 15, t0 + 17);
        pulse_start();
        wait_cyc(t0 + 15);
        rst_n = 1'b0;
        wait_cyc(t0 + 18);
        rst_n = 1'b1;
        wait_cyc(t0 + 20);
        t0 = cyc;
        expect_sig("cleared_busy", S_BUSY, t0 + 1, t0 + 2, 1);
        expect_sig("cleared_idx", S_IDX, t0 + 2, t0 + 2, 1);
        expect_sig("cleared_chirp", S_CHIRP, t0 + 1, t0 + 3, 1);
        expect_sig("cleared_done", S_DONE, t0 + 3, t0 + 3, 1);
        expect_sig("cleared_end", S_BUSY, t0 + 3, t0 + 3, 0);
        pulse_start();
        wait_cyc(t0 + 5);

        // nprof_act of 0 behaves as a single profile.
        cfg_bus.nprof_act = 3'd0;
        t0 = cyc;
        expect_sig("nact0_idx", S_IDX, t0 + 1, t0 + 1, 0);
        expect_sig("nact0_busy", S_BUSY, t0 + 1, t0 + 1, 1);
        expect_sig("nact0_done", S_DONE, t0 + 2, t0 + 2, 1);
        expect_sig("nact0_end", S_BUSY, t0 + 2, t0 + 2, 0);
        pulse_start();
        wait_cyc(t0 + 4);

        // Full-scale ramp count: 255 back-to-back wraps.
        cfg_write(2'd0, 8'd3, 8'd255, 8'd0);
        cfg_bus.nprof_act = 3'd1;
        tick();
        t0 = cyc;
        expect_sig("maxramp_mid", S_CHIRP, t0 + 100, t0 + 100, 0);
        expect_sig("maxramp_last", S_CHIRP, t0 + 256, t0 + 256, 0);
        expect_sig("maxramp_last", S_STEP, t0 + 256, t0 + 256, 3);
        expect_sig("maxramp_last", S_BUSY, t0 + 256, t0 + 256, 1);
        expect_sig("maxramp_done", S_DONE, t0 + 256, t0 + 256, 0);
        expect_sig("maxramp_done", S_DONE, t0 + 257, t0 + 257, 1);
        expect_sig("maxramp_end", S_BUSY, t0 + 257, t0 + 257, 0);
        expect_sig("maxramp_end", S_CHIRP, t0 + 257, t0 + 257, 1);
        pulse_start();
        wait_cyc(t0 + 2);
        wrap = 1'b1;
        wait_cyc(t0 + 257);
        wrap = 1'b0;
        wait_cyc(t0 + 260);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chirp_sequencer.md
# chirp_sequencer

Single-clock scheduler that drives the DAC interface's chirp generator. It holds a small table of chirp profiles, each with a step size, a ramp count and an idle gap. It issues the device frame-latch strobe `dce_n` and steps through the profiles on request, optionally looping. It sits between the host configuration bus and the DAC interface, and replaces hard-wired `stepsize` with a sequenced value.

## Interface
Parameters:
- `DWIDTH`, 8, DAC word width; also the width of the step size.
- `NPROF`, 4, number of profile slots. Must be a power of 2, ≥2.
- `FRAME_LEN`, 10, `clk10m` cycles per DAC frame. Must be ≥ DWIDTH+1.
- `CW`, 8, width of the ramp-count and gap-count fields.

Ports:
- `clk10m`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  profile write strobe.
- `cfg_addr`  in  log2(NPROF)  profile slot to write.
- `cfg_step`  in  DWIDTH  step size for the slot.
- `cfg_nramp`  in  CW  number of ramps (turnarounds) for the slot.
- `cfg_gap`  in  CW  idle frames after the ramps.
- `nprof_act`  in  log2(NPROF)+1  profiles in the sequence, 1..NPROF. 0 is treated as 1.
- `loop`  in  1  restart at profile 0 after the last profile.
- `start`  in  1  single-cycle pulse that begins the sequence.
- `stop`  in  1  single-cycle pulse that aborts the sequence.
- `wrap`  in  1  single-cycle turnaround pulse from the DAC interface. Synchronous to `clk10m`.
- `stepsize`  out  DWIDTH  step size presented to the DAC interface.
- `dce_n`  out  1  frame-latch strobe; low for 1 cycle per frame.
- `chirp_n`  out  1  low while ramping.
- `prof_idx`  out  log2(NPROF)  index of the active profile.
- `busy`  out  1  sequence in progress.
- `done`  out  1  1-cycle pulse when a non-looping sequence completes.

## Operation
- Profile table: NPROF entries of {step, nramp, gap}. All entries reset to 0.
  - `cfg_we` writes an entry in 1 cycle. Writes are legal while busy.
  - A write takes effect at the next LOAD of that slot.
- FSM states: IDLE, LOAD, RAMP, GAP.
  - IDLE: `busy`=0. `start` moves to LOAD with idx=0.
  - LOAD: 1 cycle. Latches the entry at idx into working registers and clears the counters. Goes to RAMP if nramp≠0; else to GAP if gap≠0; else to NEXT.
  - RAMP: `stepsize`=latched step and `chirp_n`=0. Each `wrap` increments the ramp counter. When the count reaches nramp, goes to GAP, or to NEXT if gap=0.
  - GAP: `stepsize`=0 and `chirp_n`=1. Counts `dce_n` strobes. After `gap` strobes, goes to NEXT.
- NEXT is a decision, not a state:
  - If idx < nprof_act−1: idx+1, then LOAD.
  - Else if `loop`=1: idx=0, then LOAD.
  - Else: IDLE with `done` pulsed for 1 cycle.
- Frame timer:
  - The counter runs 0..FRAME_LEN−1 only while `busy`=1.
  - `dce_n`=0 on the cycle the count equals FRAME_LEN−1.
  - The counter clears in IDLE, so the first strobe comes FRAME_LEN cycles after entering LOAD.
- `stop` in any busy state goes to IDLE on the next edge.
  - `done` stays 0.
  - `stepsize` returns to 0 and `chirp_n` returns to 1.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the block stays IDLE.
- `start` while busy is ignored.
- `wrap` outside RAMP is ignored.
- Counter width rules:
  - Counters are CW bits wide and compare for equality, with no overflow past nramp or gap.
  - nramp=2^CW−1 is legal.

## Timing
- Reset values: `stepsize`=0, `dce_n`=1, `chirp_n`=1, `prof_idx`=0, `busy`=0, `done`=0, FSM in IDLE.
- All outputs are registered.
- Sequence timing from `start` high at cycle 0:
  - Cycle 1: `busy`=1 and state is LOAD.
  - Cycle 2: RAMP outputs are valid (`stepsize`, `chirp_n`=0).
- `wrap` at cycle k, when it completes the last ramp, moves the FSM out of RAMP at cycle k+1.
- `done` is asserted on the same cycle `busy` falls.
- `rst_n` assertion mid-sequence forces the reset values immediately (asynchronous) and clears the table.

## Structure
- Package `chirp_seq_pkg` holds:
  - the state enum {IDLE, LOAD, RAMP, GAP};
  - a profile record type parameterised by DWIDTH and CW;
  - localparams for the index width, log2(NPROF).
- Sub-module `dac_frame_timer`: an enable-gated modulo-FRAME_LEN counter that produces the registered `dce_n` and an internal frame tick.

## Test plan
- Basic sequence:
  - Stimulus: slot 0 = {step 5, nramp 2, gap 3}, nprof_act=1, loop=0, `start`, two `wrap` pulses.
  - Required: `chirp_n` low from cycle 2 until the cycle after the 2nd wrap, then 3 `dce_n` strobes with `stepsize`=0, then `done` pulse and `busy`=0.
- Multi-profile with loop:
  - Stimulus: 3 profiles with steps 1, 2, 3; nprof_act=3; loop=1.
  - Required: `prof_idx` goes 0→1→2→0 and `stepsize` tracks the slot; `done` never asserts.
- Zero-field skips:
  - Stimulus: a slot with nramp=0, gap=4; then a slot with nramp=0, gap=0.
  - Required: the first enters GAP directly, with no `chirp_n` low. The second passes LOAD→NEXT in 1 cycle.
- Abort:
  - Stimulus: `stop` mid-RAMP.
  - Required: IDLE next cycle, `stepsize`=0, `chirp_n`=1, `done`=0.
  - Stimulus: `start` and `stop` asserted together in IDLE.
  - Required: stays IDLE.
- Frame cadence with FRAME_LEN=10:
  - Required: `dce_n` low exactly every 10 cycles while busy, first strobe 10 cycles after LOAD, none in IDLE.
  - Required: a stray `wrap` in GAP leaves the counts unchanged.
- Reset mid-operation and live config write:
  - Stimulus: `rst_n` pulsed low during GAP.
  - Required: all outputs at their reset values while low, and table reads back 0.
  - Stimulus: rewrite slot 1 while slot 0 is active.
  - Required: slot 1 uses the new values when it is loaded.
